// File: rtl/requant_pkg.sv
// Shared types and default widths for the requantiser slice.
package requant_pkg;

  typedef enum logic {
    RND_AWAY  = 1'b0,
    RND_FLOOR = 1'b1
  } rnd_mode_e;

  localparam int unsigned DEF_IN_W    = 32;
  localparam int unsigned DEF_OUT_W   = 8;
  localparam int unsigned DEF_LANES   = 4;
  localparam int unsigned DEF_SHIFT_W = 5;
  localparam int unsigned DEF_CNT_W   = 16;

endpackage

// File: rtl/requant_lane_round.sv
// Combinational per-lane rounding bias and arithmetic right shift in IN_W+1 bits.
module requant_lane_round
  import requant_pkg::*;
#(
  parameter int unsigned IN_W    = DEF_IN_W,
  parameter int unsigned SHIFT_W = DEF_SHIFT_W
) (
  input  logic [IN_W-1:0]    x,
  input  logic [SHIFT_W-1:0] sh,
  input  logic               mode,
  output logic [IN_W:0]      q
);

  localparam logic signed [IN_W:0] ONE = (IN_W+1)'(1);

  logic signed [IN_W:0] xe;
  logic signed [IN_W:0] bias;
  logic signed [IN_W:0] sum;

  // The extra bit keeps x + bias from overflowing at the most positive input.
  always_comb begin
    xe   = $signed({x[IN_W-1], x});
    bias = '0;
    if ((sh != '0) && (mode == RND_AWAY)) begin
      bias = ONE << (sh - SHIFT_W'(1));
      if (x[IN_W-1]) bias = bias - ONE;
    end
    sum = xe + bias;
    q   = sum >>> sh;
  end

endmodule

// File: rtl/requant_stream.sv
// Two-stage multi-lane requantiser: round/shift, then saturate, with valid/ready flow control.
module requant_stream
  import requant_pkg::*;
#(
  parameter int unsigned IN_W    = DEF_IN_W,
  parameter int unsigned OUT_W   = DEF_OUT_W,
  parameter int unsigned LANES   = DEF_LANES,
  parameter int unsigned SHIFT_W = DEF_SHIFT_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0]     in_shift,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_count
);

  localparam int unsigned SH_LIM = ((IN_W - 1) < ((1 << SHIFT_W) - 1)) ?
                                   (IN_W - 1) : ((1 << SHIFT_W) - 1);
  localparam logic signed [IN_W:0] QMAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] QMIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                   adv1;
  logic                   adv2;
  logic                   load2;
  logic                   s1_valid;
  logic [SHIFT_W-1:0]     sh_c;
  logic [IN_W:0]          rq   [LANES];
  logic [IN_W:0]          s1_q [LANES];
  logic [LANES*OUT_W-1:0] sat_d;
  logic [LANES-1:0]       sat_f;
  logic [CNT_W:0]         npop;
  logic [CNT_W:0]         cnt_sum;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign load2    = adv2 && s1_valid;

  assign sh_c = (32'(in_shift) > SH_LIM) ? SHIFT_W'(SH_LIM) : in_shift;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane_round #(
      .IN_W    (IN_W),
      .SHIFT_W (SHIFT_W)
    ) u_round (
      .x    (in_data[g*IN_W +: IN_W]),
      .sh   (sh_c),
      .mode (in_mode),
      .q    (rq[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (adv1) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      for (int unsigned i = 0; i < LANES; i++) s1_q[i] <= rq[i];
    end
  end

  always_comb begin
    sat_d = '0;
    sat_f = '0;
    npop  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if ($signed(s1_q[i]) > QMAX) begin
        sat_d[i*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
        sat_f[i] = 1'b1;
      end else if ($signed(s1_q[i]) < QMIN) begin
        sat_d[i*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
        sat_f[i] = 1'b1;
      end else begin
        sat_d[i*OUT_W +: OUT_W] = s1_q[i][OUT_W-1:0];
      end
      npop = npop + (CNT_W+1)'(sat_f[i]);
    end
    cnt_sum = {1'b0, sat_count} + npop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_d;
        out_sat  <= sat_f;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count <= '0;
    else if (sat_clr) sat_count <= '0;
    else if (load2) sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_requant_stream.sv
// Scoreboard bench for requant_stream: directed cases plus randomized traffic vs. an arithmetic model.
module tb_requant_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_mode, out_valid, out_ready, sat_clr;
  logic [127:0] in_data;
  logic [4:0]   in_shift;
  logic [31:0]  out_data;
  logic [3:0]   out_sat;
  logic [5:0]   sat_count;

  logic        v16, r16, ov16, sc16;
  logic [15:0] d16;
  logic [4:0]  sh16;
  logic [7:0]  od16;
  logic        os16;
  logic [3:0]  cnt16;

  int vectors = 0;
  int miscompares = 0;
  logic [35:0] exp_q[$];
  int sat_model = 0;

  always #5 clk = ~clk;

  requant_stream #(
    .IN_W(32), .OUT_W(8), .LANES(4), .SHIFT_W(5), .CNT_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .sat_clr(sat_clr), .sat_count(sat_count)
  );

  requant_stream #(
    .IN_W(16), .OUT_W(8), .LANES(1), .SHIFT_W(5), .CNT_W(4)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
    .in_data(d16), .in_shift(sh16), .in_mode(1'b0),
    .out_valid(ov16), .out_ready(1'b1), .out_data(od16),
    .out_sat(os16), .sat_clr(sc16), .sat_count(cnt16)
  );

  // Round-half-away is |x|/2^s rounded to nearest with ties outward; floor is true floor division.
  function automatic logic [35:0] ref_beat(input logic [127:0] d, input int sh, input logic md);
    logic [31:0] od;
    logic [3:0]  os;
    longint x, p, q, mag;
    for (int i = 0; i < 4; i++) begin
      x = longint'($signed(d[i*32 +: 32]));
      p = longint'(1) << sh;
      if (sh == 0) q = x;
      else if (md) q = (x >= 0) ? x / p : -((-x + p - 1) / p);
      else begin
        mag = (x < 0) ? -x : x;
        mag = (mag + p / 2) / p;
        q = (x < 0) ? -mag : mag;
      end
      if (q > 127) begin od[i*8 +: 8] = 8'h7F; os[i] = 1'b1; end
      else if (q < -128) begin od[i*8 +: 8] = 8'h80; os[i] = 1'b1; end
      else begin od[i*8 +: 8] = q[7:0]; os[i] = 1'b0; end
    end
    return {os, od};
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int e);
    return {32'(e), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard push: expected response recorded when a beat is accepted.
  always @(negedge clk) begin
    logic [35:0] e;
    if (rst_n && in_valid && in_ready) begin
      e = ref_beat(in_data, int'(in_shift), in_mode);
      exp_q.push_back(e);
      sat_model = sat_model + $countones(e[35:32]);
      if (sat_model > 63) sat_model = 63;
    end
  end

  // Monitor: pops on every transfer and checks hold-stability during stalls.
  logic        hold = 1'b0;
  logic [35:0] held;
  int          beat_no = 0;
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        vectors++;
        if (!out_valid || {out_sat, out_data} !== held) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid, {out_sat, out_data}, held);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat%0d: unexpected output %h, nothing expected", beat_no, {out_sat, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_sat, out_data} !== e) begin
            miscompares++;
            $display("FAIL beat%0d: got sat %b data %h expected sat %b data %h",
                     beat_no, out_sat, out_data, e[35:32], e[31:0]);
          end
        end
        beat_no++;
      end
      hold = out_valid && !out_ready;
      held = {out_sat, out_data};
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic [4:0] sh, input logic md);
    int n = 0;
    @(posedge clk); #1;
    in_data = d; in_shift = sh; in_mode = md; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic t16(input logic [15:0] x, input logic [7:0] exp);
    @(posedge clk); #1;
    d16 = x; sh16 = 5'd31; v16 = 1'b1;
    @(negedge clk);
    check("dut16_ready", 64'(r16), 64'd1);
    @(posedge clk); #1; v16 = 1'b0;
    @(posedge clk); #1;
    check("dut16_valid", 64'(ov16), 64'd1);
    check("dut16_clamp", 64'(od16), 64'(exp));
  endtask

  logic [127:0] bp [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = 1'b0;
    out_ready = 1'b1; sat_clr = 1'b0;
    v16 = 1'b0; d16 = '0; sh16 = '0; sc16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Latency and basic rounding.
    send_beat(pack4(1000, -1000, 1004, -1004), 5'd3, 1'b0);
    check("lat_1cyc", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_2cyc", 64'(out_valid), 64'd1);
    check("lat_data", 64'(out_data), 64'({8'd130, 8'd126, 8'd131, 8'd125}));
    wait_drain();
    send_beat(pack4(1000, -1000, 1004, -1004), 5'd3, 1'b1);
    send_beat(pack4(-2, -3, -1, 1), 5'd1, 1'b0);
    wait_drain();

    // Saturation and counter, then clear colliding with a saturating load.
    send_beat(pack4(2000, -2000, 1020, -1032), 5'd3, 1'b0);
    wait_drain();
    check("sat_count_4", 64'(sat_count), 64'd4);
    send_beat(pack4(2000, -2000, 1020, -1032), 5'd3, 1'b0);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("sat_clr_prio", 64'(sat_count), 64'd0);
    wait_drain();
    check("sat_clr_hold", 64'(sat_count), 64'd0);

    // Extremes.
    send_beat({32'h0, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF}, 5'd1, 1'b0);
    send_beat({32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000}, 5'd31, 1'b0);
    send_beat({32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000}, 5'd31, 1'b1);
    wait_drain();
    t16(16'h4000, 8'd1);
    t16(16'h8000, 8'hFF);

    // Backpressure: two beats absorbed, then in_ready drops.
    for (int i = 0; i < 4; i++) bp[i] = pack4(i * 40 + 8, -i * 72, 500 + i, -7 - i);
    begin
      int k = 0;
      @(posedge clk); #1; out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
        in_data = bp[k]; in_shift = 5'd2; in_mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        if (in_ready) k++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", 64'(k), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(negedge clk); check("bp_rel0", 64'(out_valid), 64'd1);
      @(negedge clk); check("bp_rel1", 64'(out_valid), 64'd1);
      @(negedge clk); check("bp_rel2", 64'(out_valid), 64'd0);
      send_beat(bp[2], 5'd2, 1'b0);
      send_beat(bp[3], 5'd2, 1'b0);
      wait_drain();
    end

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    send_beat(pack4(300, 301, 302, 303), 5'd0, 1'b0);
    send_beat(pack4(-300, 5, 6, 7), 5'd0, 1'b0);
    #3; rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_count", 64'(sat_count), 64'd0);
    exp_q.delete();
    sat_model = 0;
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic against the model.
    begin
      int sent = 0;
      int cyc = 0;
      bit acc = 0;
      logic [127:0] d;
      while (sent < 600 && cyc < 20000) begin
        @(posedge clk); #1;
        cyc++;
        if (acc) begin in_valid = 1'b0; acc = 0; end
        out_ready = ($urandom_range(0, 9) < 7);
        if (!in_valid && $urandom_range(0, 9) < 7) begin
          for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
              0: d[i*32 +: 32] = $urandom;
              1: d[i*32 +: 32] = 32'($signed($urandom_range(0, 4000)) - 2000);
              2: d[i*32 +: 32] = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
              default: d[i*32 +: 32] = 32'h8000_0000 + 32'($urandom_range(0, 3));
            endcase
          end
          in_data = d; in_shift = 5'($urandom_range(0, 31)); in_mode = 1'($urandom);
          in_valid = 1'b1;
        end
        @(negedge clk);
        if (in_valid && in_ready) begin acc = 1; sent++; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      check("rand_sent", 64'(sent), 64'd600);
      wait_drain();
      check("rand_sat_count", 64'(sat_count), 64'(sat_model));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
